multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TO_LIMIT, default 64: memory-wait timeout in cycles, used only under MCTRL_TIMEOUT_EN.
REQ-002 i_clk  input  1  rising-edge clock; single clock domain.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_instr  input  32  instruction register contents.
REQ-005 i_br_equal, i_br_less  input  1 each  branch comparator results.
REQ-006 i_mem_ack  input  1  memory transfer done, one-cycle pulse.
REQ-007 o_mem_req  output  1  memory request, held until i_mem_ack.
REQ-008 o_mem_we  output  1  store qualifier for o_mem_req.
REQ-009 o_imem_sel  output  1  1 = address from PC (fetch); 0 = address from ALU (data).
REQ-010 o_ir_we, o_pc_we, o_rd_wren  output  1 each  instruction-register, PC and register-file write enables.
REQ-011 o_pc_sel  output  1  1 = next PC from ALU result; 0 = PC+4.
REQ-012 o_opa_sel  output  1  1 = rs1; 0 = PC.
REQ-013 o_opb_sel  output  1  operand-B mux select: 1 = rs2, 0 = immediate.
REQ-014 o_alu_op  output  4  ALU operation.
REQ-015 o_br_un  output  1  unsigned compare request, equal to funct3[1].
REQ-016 o_wb_sel  output  2  00 = ALU, 01 = load data, 10 = PC+4.
REQ-017 o_state  output  3  current state (debug).
REQ-018 o_trap  output  1  sticky trap flag.

Function
REQ-019 States SHALL be FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=111. All outputs SHALL be Moore or state+instruction decoded; an output not listed for a state SHALL be 0.
REQ-020 FETCH: o_mem_req=1, o_imem_sel=1. On i_mem_ack, o_ir_we=1 in the same cycle and next state is DECODE. Otherwise remain in FETCH.
REQ-021 DECODE: one cycle. Next state is EXEC if opcode is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode goes to TRAP.
REQ-022 EXEC operand selects:
- R-type: o_opa_sel=1, o_opb_sel=1.
- OP-IMM, load, store, JALR: o_opa_sel=1, o_opb_sel=0.
- Branch, JAL, AUIPC: o_opa_sel=0, o_opb_sel=0.
- LUI: o_opb_sel=0.
REQ-023 o_alu_op encoding:
- R-type: {funct7[5], funct3}.
- OP-IMM: {funct7[5] only when funct3=101, else 0, funct3}.
- LUI: 1111 (pass B).
- All others: 0000 (ADD).
REQ-024 EXEC next state: load/store go to MEM; branch goes to FETCH; all others go to WB.
REQ-025 Branch in EXEC: o_pc_we=1, o_pc_sel=taken. Taken conditions:
- BEQ: eq. BNE: !eq.
- BLT/BLTU: less. BGE/BGEU: !less.
- Reserved funct3 010/011 go to TRAP instead.
REQ-026 MEM: o_mem_req=1, o_imem_sel=0, o_mem_we=store. On ack:
- store: o_pc_we=1, o_pc_sel=0, next FETCH.
- load: next WB.
REQ-027 WB: o_rd_wren=1 unless rd=0, o_pc_we=1.
- o_wb_sel: 01 for load, 10 for JAL/JALR, else 00.
- o_pc_sel: 1 for JAL/JALR, else 0.
- Next state FETCH.
- Each instruction updates PC exactly once.
REQ-028 TRAP: o_trap=1; all enables and o_mem_req=0; state held until reset.
REQ-029 i_mem_ack outside FETCH/MEM SHALL be ignored.
REQ-030 o_mem_req SHALL be stable high from request until the ack cycle inclusive, and low the cycle after.

Reset
REQ-031 While i_rst_n=0: state=FETCH, o_trap=0, all outputs 0 (o_mem_req forced low).
REQ-032 First cycle after release: FETCH with o_mem_req=1.
REQ-033 Reset mid-request SHALL abort immediately and asynchronously. No ir/pc/rd write SHALL occur in that cycle.

Configuration
REQ-034 Macro MCTRL_TIMEOUT_EN defined:
- An 8-bit wait counter counts consecutive no-ack cycles in FETCH/MEM and clears on ack or state change.
- At count == TO_LIMIT, next state is TRAP.
REQ-035 Macro MCTRL_TIMEOUT_EN undefined: no counter exists, FETCH/MEM wait indefinitely, and TO_LIMIT has no effect.

Verification
REQ-036 ADD x3,x1,x2 (0x002081B3), ack after 2 cycles -> FETCH(3) DECODE EXEC WB; o_opb_sel=1 in EXEC; o_alu_op=0000; o_rd_wren=1 in WB.
REQ-037 LW x5,8(x1), fetch and data ack each after 1 cycle -> EXEC o_opb_sel=0, MEM o_imem_sel=0, WB o_wb_sel=01, 5 states total.
REQ-038 BEQ with i_br_equal=1 -> EXEC o_pc_we=1, o_pc_sel=1, next FETCH, no WB. With i_br_equal=0 -> o_pc_sel=0.
REQ-039 Opcode 0x0000007F -> DECODE then TRAP; o_trap=1 held 20 cycles; reset clears it to FETCH.
REQ-040 i_rst_n low during MEM of SW -> o_mem_req=0 in that cycle; after release, FETCH; no o_pc_we pulse observed.
REQ-041 MCTRL_TIMEOUT_EN, TO_LIMIT=64, no ack in FETCH -> TRAP entered after 64 wait cycles. Without the macro, still in FETCH after 1000 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Control unit for a multicycle RV32I-style datapath. Sequences each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the
// datapath mux selects and write enables. An unknown opcode or a reserved
// branch funct3 parks the controller in TRAP until reset.
//
// Optional build macro:
//   MCTRL_TIMEOUT_EN  adds an 8-bit wait counter. TRAP is entered once
//                     FETCH or MEM has waited TO_LIMIT consecutive cycles
//                     without i_mem_ack. When the macro is not defined, the
//                     controller waits for an ack indefinitely.
//
// Parameters:
//   TO_LIMIT    memory-wait timeout in cycles (only with MCTRL_TIMEOUT_EN)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_instr      instruction register contents
//   i_br_equal   branch comparator: rs1 == rs2
//   i_br_less    branch comparator: rs1 <  rs2
//   i_mem_ack    memory transfer done (one-cycle pulse)
//   o_mem_req    memory request, held until the ack cycle
//   o_mem_we     store qualifier for o_mem_req
//   o_imem_sel   1 = address from PC, 0 = address from ALU
//   o_ir_we      instruction register write enable
//   o_pc_we      PC write enable
//   o_rd_wren    register file write enable
//   o_pc_sel     1 = next PC from ALU, 0 = PC+4
//   o_opa_sel    1 = rs1, 0 = PC
//   o_opb_sel    1 = rs2, 0 = immediate
//   o_alu_op     ALU operation
//   o_br_un      unsigned branch compare
//   o_wb_sel     00 = ALU, 01 = load data, 10 = PC+4
//   o_state      current state (debug)
//   o_trap       sticky trap flag
//
// State table
//   state  | meaning
//   FETCH  | instruction fetch, waiting for i_mem_ack
//   DECODE | opcode legality check
//   EXEC   | ALU operation; branches resolve here
//   MEM    | load/store data access, waiting for i_mem_ack
//   WB     | register write-back and PC update
//   TRAP   | illegal instruction or timeout; held until reset
// ============================================================================
module multicycle_ctrl #(
   parameter int TO_LIMIT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_instr,
   input  logic        i_br_equal,
   input  logic        i_br_less,
   input  logic        i_mem_ack,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic        o_imem_sel,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic        o_rd_wren,
   output logic        o_pc_sel,
   output logic        o_opa_sel,
   output logic        o_opb_sel,
   output logic [3:0]  o_alu_op,
   output logic        o_br_un,
   output logic [1:0]  o_wb_sel,
   output logic [2:0]  o_state,
   output logic        o_trap
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'b000,
      S_DECODE = 3'b001,
      S_EXEC   = 3'b010,
      S_MEM    = 3'b011,
      S_WB     = 3'b100,
      S_TRAP   = 3'b111
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   state_t state;
   state_t state_nxt;
   logic   trap_q;

   // instruction fields
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       f7_b5;

   assign opcode = i_instr[6:0];
   assign rd     = i_instr[11:7];
   assign funct3 = i_instr[14:12];
   assign f7_b5  = i_instr[30];

   logic unused_instr;
   assign unused_instr = ^{i_instr[31], i_instr[29:15]};

   logic is_r, is_imm, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
   logic legal, br_rsvd, br_taken;

   assign is_r     = (opcode == OP_R);
   assign is_imm   = (opcode == OP_IMM);
   assign is_ld    = (opcode == OP_LOAD);
   assign is_st    = (opcode == OP_STORE);
   assign is_br    = (opcode == OP_BR);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);
   assign legal    = is_r | is_imm | is_ld | is_st | is_br | is_jal | is_jalr
                   | is_lui | is_auipc;

   // funct3 010/011 are unassigned branch encodings
   assign br_rsvd = is_br && (funct3[2:1] == 2'b01);

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:          br_taken = i_br_equal;
         3'b001:          br_taken = ~i_br_equal;
         3'b100, 3'b110:  br_taken = i_br_less;
         3'b101, 3'b111:  br_taken = ~i_br_less;
         default:         br_taken = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Memory wait timeout
   // ------------------------------------------------------------------------
   logic waiting;
   logic wait_expired;

   assign waiting = (state == S_FETCH) || (state == S_MEM);

`ifdef MCTRL_TIMEOUT_EN
   localparam logic [7:0] TO_LIM8 = 8'(TO_LIMIT);

   logic [7:0] wait_cnt;

   // expires on the TO_LIMIT-th consecutive cycle without an ack
   assign wait_expired = waiting && !i_mem_ack && ((wait_cnt + 8'd1) == TO_LIM8);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_cnt <= 8'd0;
      end else if (!waiting || i_mem_ack || wait_expired || (state_nxt != state)) begin
         wait_cnt <= 8'd0;
      end else begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   logic unused_to_limit;
   assign unused_to_limit = ^8'(TO_LIMIT) ^ waiting;
   assign wait_expired    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: begin
            if (wait_expired)   state_nxt = S_TRAP;
            else if (i_mem_ack) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (is_ld || is_st) state_nxt = S_MEM;
            else if (br_rsvd)   state_nxt = S_TRAP;
            else if (is_br)     state_nxt = S_FETCH;
            else                state_nxt = S_WB;
         end
         S_MEM: begin
            if (wait_expired)   state_nxt = S_TRAP;
            else if (i_mem_ack) state_nxt = is_st ? S_FETCH : S_WB;
         end
         S_WB:    state_nxt = S_FETCH;
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_TRAP;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= S_FETCH;
         trap_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         trap_q <= trap_q | (state_nxt == S_TRAP);
      end
   end

   // ------------------------------------------------------------------------
   // Output decode (state + instruction)
   // ------------------------------------------------------------------------
   logic       mem_req_c, mem_we_c, imem_sel_c, ir_we_c, pc_we_c, rd_wren_c;
   logic       pc_sel_c, opa_sel_c, opb_sel_c, br_un_c;
   logic [3:0] alu_op_c;
   logic [1:0] wb_sel_c;

   always_comb begin
      mem_req_c  = 1'b0;
      mem_we_c   = 1'b0;
      imem_sel_c = 1'b0;
      ir_we_c    = 1'b0;
      pc_we_c    = 1'b0;
      rd_wren_c  = 1'b0;
      pc_sel_c   = 1'b0;
      opa_sel_c  = 1'b0;
      opb_sel_c  = 1'b0;
      br_un_c    = 1'b0;
      alu_op_c   = 4'b0000;
      wb_sel_c   = 2'b00;
      case (state)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            imem_sel_c = 1'b1;
            ir_we_c    = i_mem_ack;
         end
         S_EXEC: begin
            if (is_r) begin
               opa_sel_c = 1'b1;
               opb_sel_c = 1'b1;
               alu_op_c  = {f7_b5, funct3};
            end else if (is_imm) begin
               opa_sel_c = 1'b1;
               // bit 30 of an I-immediate only means "arithmetic" for SRAI
               alu_op_c  = {(funct3 == 3'b101) ? f7_b5 : 1'b0, funct3};
            end else if (is_ld || is_st || is_jalr) begin
               opa_sel_c = 1'b1;
            end else if (is_lui) begin
               alu_op_c  = 4'b1111;
            end
            if (is_br) begin
               br_un_c  = funct3[1];
               pc_we_c  = ~br_rsvd;
               pc_sel_c = br_taken & ~br_rsvd;
            end
         end
         S_MEM: begin
            mem_req_c = 1'b1;
            mem_we_c  = is_st;
            // stores retire here, so the PC advances on the data ack
            pc_we_c   = is_st & i_mem_ack;
         end
         S_WB: begin
            rd_wren_c = (rd != 5'd0);
            pc_we_c   = 1'b1;
            pc_sel_c  = is_jal | is_jalr;
            if (is_ld)                 wb_sel_c = 2'b01;
            else if (is_jal || is_jalr) wb_sel_c = 2'b10;
         end
         default: ;
      endcase
   end

   // reset gates the decoded outputs so a request aborts without waiting
   // for a clock edge and no write enable can escape during reset
   assign o_mem_req  = mem_req_c  & i_rst_n;
   assign o_mem_we   = mem_we_c   & i_rst_n;
   assign o_imem_sel = imem_sel_c & i_rst_n;
   assign o_ir_we    = ir_we_c    & i_rst_n;
   assign o_pc_we    = pc_we_c    & i_rst_n;
   assign o_rd_wren  = rd_wren_c  & i_rst_n;
   assign o_pc_sel   = pc_sel_c   & i_rst_n;
   assign o_opa_sel  = opa_sel_c  & i_rst_n;
   assign o_opb_sel  = opb_sel_c  & i_rst_n;
   assign o_br_un    = br_un_c    & i_rst_n;
   assign o_alu_op   = alu_op_c   & {4{i_rst_n}};
   assign o_wb_sel   = wb_sel_c   & {2{i_rst_n}};
   assign o_state    = state;
   assign o_trap     = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_instr = 32'h0;
   logic        i_br_equal = 1'b0;
   logic        i_br_less = 1'b0;
   logic        i_mem_ack = 1'b0;
   logic        o_mem_req, o_mem_we, o_imem_sel, o_ir_we, o_pc_we, o_rd_wren;
   logic        o_pc_sel, o_opa_sel, o_opb_sel, o_br_un, o_trap;
   logic [3:0]  o_alu_op;
   logic [1:0]  o_wb_sel;
   logic [2:0]  o_state;

   multicycle_ctrl #(.TO_LIMIT(64)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr),
      .i_br_equal(i_br_equal), .i_br_less(i_br_less), .i_mem_ack(i_mem_ack),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_imem_sel(o_imem_sel),
      .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_rd_wren(o_rd_wren),
      .o_pc_sel(o_pc_sel), .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel),
      .o_alu_op(o_alu_op), .o_br_un(o_br_un), .o_wb_sel(o_wb_sel),
      .o_state(o_state), .o_trap(o_trap)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, imem_sel, ir_we, pc_we, rd_wren, pc_sel, opa, opb;
      logic [3:0] alu;
      logic       br_un;
      logic [1:0] wb;
      logic       trap;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   obs_t  mon_e, mon_a;
   string mon_t;

   // monitor: one expected snapshot per pushed cycle, compared mid-cycle
   initial begin
      forever begin
         @(negedge i_clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_a = {o_state, o_mem_req, o_mem_we, o_imem_sel, o_ir_we, o_pc_we,
                     o_rd_wren, o_pc_sel, o_opa_sel, o_opb_sel, o_alu_op, o_br_un,
                     o_wb_sel, o_trap};
            n_cmp++;
            if (mon_a !== mon_e) begin
               n_bad++;
               $display("FAIL %s: got %h want %h (st got %b want %b)",
                        mon_t, mon_a, mon_e, mon_a.st, mon_e.st);
            end
         end
      end
   end

   function automatic obs_t ex_fetch(input logic ack);
      obs_t o = '0;
      o.st = 3'b000; o.mem_req = 1'b1; o.imem_sel = 1'b1; o.ir_we = ack;
      return o;
   endfunction

   function automatic obs_t ex_decode();
      obs_t o = '0;
      o.st = 3'b001;
      return o;
   endfunction

   function automatic obs_t ex_exec(input logic opa, input logic opb, input logic [3:0] alu,
                                    input logic br_un, input logic pc_we, input logic pc_sel);
      obs_t o = '0;
      o.st = 3'b010; o.opa = opa; o.opb = opb; o.alu = alu;
      o.br_un = br_un; o.pc_we = pc_we; o.pc_sel = pc_sel;
      return o;
   endfunction

   function automatic obs_t ex_mem(input logic we, input logic pc_we);
      obs_t o = '0;
      o.st = 3'b011; o.mem_req = 1'b1; o.mem_we = we; o.pc_we = pc_we;
      return o;
   endfunction

   function automatic obs_t ex_wb(input logic rd_wren, input logic [1:0] wb, input logic pc_sel);
      obs_t o = '0;
      o.st = 3'b100; o.rd_wren = rd_wren; o.pc_we = 1'b1; o.wb = wb; o.pc_sel = pc_sel;
      return o;
   endfunction

   function automatic obs_t ex_trap();
      obs_t o = '0;
      o.st = 3'b111; o.trap = 1'b1;
      return o;
   endfunction

   // called at posedge+1; drives this cycle's inputs and queues its expectation
   task automatic step(input string t, input obs_t e, input logic ack);
      i_mem_ack = ack;
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge i_clk);
      #1;
      i_mem_ack = 1'b0;
   endtask

   // IR is loaded on the fetch ack, so the new word appears after it
   task automatic fetch(input logic [31:0] ins, input int nwait);
      for (int i = 0; i < nwait; i++) step("fetch_wait", ex_fetch(1'b0), 1'b0);
      step("fetch_ack", ex_fetch(1'b1), 1'b1);
      i_instr = ins;
   endtask

   task automatic do_reset(input string t);
      i_rst_n = 1'b0;
      step(t, obs_t'(0), 1'b1);
      i_rst_n = 1'b1;
      step("fetch_after_reset", ex_fetch(1'b0), 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      step("reset_state", obs_t'(0), 1'b1);
      i_rst_n = 1'b1;
      step("first_fetch", ex_fetch(1'b0), 1'b0);

      // ADD x3,x1,x2 ; an ack pulse in DECODE must be ignored
      fetch(32'h002081B3, 2);
      step("add_decode", ex_decode(), 1'b1);
      step("add_exec", ex_exec(1, 1, 4'b0000, 0, 0, 0), 1'b0);
      step("add_wb", ex_wb(1, 2'b00, 0), 1'b0);

      // SUB x3,x1,x2
      fetch(32'h402081B3, 0);
      step("sub_decode", ex_decode(), 1'b0);
      step("sub_exec", ex_exec(1, 1, 4'b1000, 0, 0, 0), 1'b0);
      step("sub_wb", ex_wb(1, 2'b00, 0), 1'b0);

      // SRAI x4,x1,3
      fetch(32'h4030D213, 0);
      step("srai_decode", ex_decode(), 1'b0);
      step("srai_exec", ex_exec(1, 0, 4'b1101, 0, 0, 0), 1'b0);
      step("srai_wb", ex_wb(1, 2'b00, 0), 1'b0);

      // ADDI x1,x0,-1 : bit 30 set but funct3=000, so plain ADD
      fetch(32'hFFF00093, 0);
      step("addi_decode", ex_decode(), 1'b0);
      step("addi_exec", ex_exec(1, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("addi_wb", ex_wb(1, 2'b00, 0), 1'b0);

      // LW x5,8(x1)
      fetch(32'h0080A283, 1);
      step("lw_decode", ex_decode(), 1'b0);
      step("lw_exec", ex_exec(1, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("lw_mem_wait", ex_mem(0, 0), 1'b0);
      step("lw_mem_ack", ex_mem(0, 0), 1'b1);
      step("lw_wb", ex_wb(1, 2'b01, 0), 1'b0);

      // SW x2,4(x1)
      fetch(32'h0020A223, 0);
      step("sw_decode", ex_decode(), 1'b0);
      step("sw_exec", ex_exec(1, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("sw_mem_wait", ex_mem(1, 0), 1'b0);
      step("sw_mem_ack", ex_mem(1, 1), 1'b1);

      // BEQ taken / not taken
      fetch(32'h00208463, 0);
      i_br_equal = 1'b1; i_br_less = 1'b0;
      step("beq_t_decode", ex_decode(), 1'b0);
      step("beq_t_exec", ex_exec(0, 0, 4'b0000, 0, 1, 1), 1'b0);
      fetch(32'h00208463, 0);
      i_br_equal = 1'b0;
      step("beq_n_decode", ex_decode(), 1'b0);
      step("beq_n_exec", ex_exec(0, 0, 4'b0000, 0, 1, 0), 1'b0);

      // BLTU taken (unsigned), BGE not taken
      fetch(32'h0020E463, 0);
      i_br_less = 1'b1;
      step("bltu_decode", ex_decode(), 1'b0);
      step("bltu_exec", ex_exec(0, 0, 4'b0000, 1, 1, 1), 1'b0);
      fetch(32'h0020D463, 0);
      step("bge_decode", ex_decode(), 1'b0);
      step("bge_exec", ex_exec(0, 0, 4'b0000, 0, 1, 0), 1'b0);
      i_br_less = 1'b0;

      // JAL x1 / JALR x1,0(x2)
      fetch(32'h010000EF, 0);
      step("jal_decode", ex_decode(), 1'b0);
      step("jal_exec", ex_exec(0, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("jal_wb", ex_wb(1, 2'b10, 1), 1'b0);
      fetch(32'h000100E7, 0);
      step("jalr_decode", ex_decode(), 1'b0);
      step("jalr_exec", ex_exec(1, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("jalr_wb", ex_wb(1, 2'b10, 1), 1'b0);

      // AUIPC x2 ; LUI x0 (rd=0 suppresses the register write)
      fetch(32'h00001117, 0);
      step("auipc_decode", ex_decode(), 1'b0);
      step("auipc_exec", ex_exec(0, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("auipc_wb", ex_wb(1, 2'b00, 0), 1'b0);
      fetch(32'h12345037, 0);
      step("lui_decode", ex_decode(), 1'b0);
      step("lui_exec", ex_exec(0, 0, 4'b1111, 0, 0, 0), 1'b0);
      step("lui_wb", ex_wb(0, 2'b00, 0), 1'b0);

      // SW aborted by reset during MEM, ack offered in the reset cycle
      fetch(32'h0020A223, 0);
      step("swr_decode", ex_decode(), 1'b0);
      step("swr_exec", ex_exec(1, 0, 4'b0000, 0, 0, 0), 1'b0);
      step("swr_mem_wait", ex_mem(1, 0), 1'b0);
      i_rst_n = 1'b0;
      step("swr_reset_in_mem", obs_t'(0), 1'b1);
      i_rst_n = 1'b1;
      step("swr_fetch_after", ex_fetch(1'b0), 1'b0);

      // fetch without ack: one wait cycle already spent above
`ifdef MCTRL_TIMEOUT_EN
      for (int i = 0; i < 63; i++) step("timeout_wait", ex_fetch(1'b0), 1'b0);
      step("timeout_trap", ex_trap(), 1'b0);
`else
      repeat (999) @(posedge i_clk);
      #1;
      step("no_timeout_fetch", ex_fetch(1'b0), 1'b0);
`endif
      do_reset("reset_after_wait");

      // illegal opcode: DECODE then TRAP for 20 cycles, acks ignored
      fetch(32'h0000007F, 0);
      step("ill_decode", ex_decode(), 1'b0);
      for (int i = 0; i < 20; i++) step("ill_trap_hold", ex_trap(), logic'(i % 2));
      do_reset("reset_from_trap");

      // reserved branch funct3=010 traps from EXEC without a PC write
      fetch(32'h0020A463, 0);
      step("brsv_decode", ex_decode(), 1'b0);
      step("brsv_exec", ex_exec(0, 0, 4'b0000, 1, 0, 0), 1'b0);
      step("brsv_trap", ex_trap(), 1'b0);
      do_reset("reset_from_brsv");

      @(posedge i_clk);
      #1;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
